// File: rtl/key_matrix_scan_pkg.sv
// Shared types and helpers for the keyboard matrix scanner.
package key_matrix_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_UPDATE,
        ST_NEXT
    } scan_state_t;

    // Index width that never collapses to zero for single-entry dimensions.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_matrix_scan_fifo.sv
// Small synchronous event FIFO with valid/ready read side and a full flag.
module key_matrix_scan_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    // DEPTH is a power of two >= 2; the extra pointer bit separates full from empty.
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop;
    logic             push_ok;

    assign o_valid = (wr_ptr != rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = o_valid && i_ready;
    assign push_ok = i_push && (!o_full || pop);
    assign o_data  = o_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/key_matrix_scan.sv
// Column-at-a-time keyboard matrix scanner with N-scan debounce and an event FIFO.
//   state  | meaning
//   IDLE   | after reset, loads settle timer
//   DRIVE  | one column pulled low, settle timer counts down
//   SAMPLE | synced rows captured into row_snap
//   UPDATE | one key of the column debounced per cycle
//   NEXT   | columns released, advance column index
module key_matrix_scan
    import key_matrix_scan_pkg::*;
#(
    parameter int NUM_COLS       = 8,
    parameter int NUM_ROWS       = 8,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4,
    localparam int CODE_W        = idx_w(NUM_COLS * NUM_ROWS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    output logic [NUM_COLS-1:0] o_cols,
    input  logic [NUM_ROWS-1:0] i_rows,
    output logic                o_evt_valid,
    input  logic                i_evt_ready,
    output logic [CODE_W-1:0]   o_evt_code,
    output logic                o_evt_press,
    output logic                o_scan_busy
);
    localparam int COL_W    = idx_w(NUM_COLS);
    localparam int ROW_W    = idx_w(NUM_ROWS);
    localparam int SET_W    = idx_w(SETTLE_CYCLES);
    localparam int CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    scan_state_t                state_q, state_d;
    logic [COL_W-1:0]           col_q;
    logic [ROW_W-1:0]           row_q;
    logic [SET_W-1:0]           settle_q;
    logic [NUM_ROWS-1:0]        row_meta, row_sync, row_snap;
    logic [NUM_KEYS-1:0]        key_q;
    logic [NUM_KEYS*CNT_W-1:0]  cnt_q;

    logic [CODE_W-1:0]          cur_code;
    logic                       cur_s, cur_k;
    logic [CNT_W-1:0]           cur_n;
    logic                       at_limit, fifo_full, fifo_accept, evt_push;
    logic [CODE_W:0]            evt_data;

    assign cur_code    = CODE_W'(col_q) * CODE_W'(NUM_ROWS) + CODE_W'(row_q);
    assign cur_s       = row_snap[row_q];
    assign cur_k       = key_q[cur_code];
    assign cur_n       = cnt_q[int'(cur_code)*CNT_W +: CNT_W];
    assign at_limit    = (cur_n == CNT_W'(DEBOUNCE_SCANS - 1));
    // A full FIFO still accepts when the consumer drains an entry in the same cycle.
    assign fifo_accept = !fifo_full || (o_evt_valid && i_evt_ready);
    assign evt_push    = (state_q == ST_UPDATE) && (cur_s != cur_k) && at_limit && fifo_accept;
    assign o_scan_busy = (state_q != ST_IDLE);
    assign o_evt_code  = evt_data[CODE_W:1];
    assign o_evt_press = evt_data[0];

    always_comb begin
        state_d = state_q;
        o_cols  = '1;
        unique case (state_q)
            ST_IDLE:   state_d = ST_DRIVE;
            ST_DRIVE: begin
                o_cols[col_q] = 1'b0;
                if (settle_q == '0) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: state_d = ST_UPDATE;
            ST_UPDATE: if (row_q == ROW_W'(NUM_ROWS - 1)) state_d = ST_NEXT;
            ST_NEXT:   state_d = ST_DRIVE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            settle_q <= '0;
            row_meta <= '1;
            row_sync <= '1;
            row_snap <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            row_meta <= i_rows;
            row_sync <= row_meta;
            case (state_q)
                ST_IDLE: settle_q <= SET_W'(SETTLE_CYCLES - 1);
                ST_DRIVE: if (settle_q != '0) settle_q <= settle_q - 1'b1;
                ST_SAMPLE: begin
                    row_snap <= ~row_sync;
                    row_q    <= '0;
                end
                ST_UPDATE: begin
                    if (row_q != ROW_W'(NUM_ROWS - 1)) row_q <= row_q + 1'b1;
                    if (cur_s == cur_k) begin
                        cnt_q[int'(cur_code)*CNT_W +: CNT_W] <= '0;
                    end else if (!at_limit) begin
                        cnt_q[int'(cur_code)*CNT_W +: CNT_W] <= cur_n + 1'b1;
                    end else if (fifo_accept) begin
                        key_q[cur_code]                      <= cur_s;
                        cnt_q[int'(cur_code)*CNT_W +: CNT_W] <= '0;
                    end
                end
                ST_NEXT: begin
                    settle_q <= SET_W'(SETTLE_CYCLES - 1);
                    col_q    <= (col_q == COL_W'(NUM_COLS - 1)) ? '0 : col_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    key_matrix_scan_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W + 1)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (evt_push),
        .i_data  ({cur_code, cur_s}),
        .o_full  (fifo_full),
        .o_valid (o_evt_valid),
        .i_ready (i_evt_ready),
        .o_data  (evt_data)
    );

endmodule
